// File: rtl/m_uindex_pkg.sv
// m_uindex_pkg: state encodings, shift control codes and default microcode vectors
package m_uindex_pkg;
  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_MEMW  = 2'd3;
  localparam logic [1:0] SC_NONE = 2'b00;
  localparam logic [1:0] SC_LOAD = 2'b01;
  localparam logic [7:0] RESET_INX_DEF   = 8'h00;
  localparam logic [7:0] TRAP_INX_DEF    = 8'hFE;
  localparam logic [7:0] ILLEGAL_INX_DEF = 8'hFD;
endpackage

// File: rtl/m_uindex_shiftcnt.sv
// m_shiftcnt: 5-bit load/decrement shift counter with busy flag and last-cycle done pulse
module m_shiftcnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] shamt,
  output logic       busy,
  output logic       done
);
  logic [4:0] cnt;
  // load on request, otherwise count down to zero and stop there
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= shamt;
    else if (cnt != '0) cnt <= cnt - 5'd1;
  assign busy = cnt != '0;
  assign done = cnt == 5'd1;
endmodule

// File: rtl/m_uindex.sv
// m_uindex: micro-sequencer choosing the next microcode index and stalling on shifts and bus waits
module m_uindex
  import m_uindex_pkg::*;
#(
  parameter logic [7:0] RESET_INX   = RESET_INX_DEF,
  parameter logic [7:0] TRAP_INX    = TRAP_INX_DEF,
  parameter logic [7:0] ILLEGAL_INX = ILLEGAL_INX_DEF
) (
  input  logic       clk,
  input  logic       RST_I,
  input  logic [7:0] rinx,
  input  logic       use_dinx,
  input  logic [9:0] instr,
  input  logic [1:0] sc_ctrl,
  input  logic [4:0] shamt,
  input  logic       stb_issue,
  input  logic       ACK_I,
  input  logic       irq,
  output logic [7:0] minx,
  output logic       progress_ucode,
  output logic       shift_busy
);
  logic [1:0] state, state_nx;
  logic [7:0] minx_q, run_inx;
  logic       load, done, wait_ack;
  assign load     = state == S_RUN && sc_ctrl == SC_LOAD && shamt != '0;
  assign wait_ack = stb_issue && !ACK_I;
  m_shiftcnt u_shiftcnt (
    .clk  (clk),
    .rst  (RST_I),
    .load (load),
    .shamt(shamt),
    .busy (shift_busy),
    .done (done)
  );
  // priority select of the index issued in normal sequencing; irq matters only at dispatch
  always_comb
    run_inx = !use_dinx          ? rinx :
              irq                ? TRAP_INX :
              instr[1:0] != 2'b11 ? ILLEGAL_INX :
              {instr[6:2], instr[9:7]};
  assign progress_ucode = state == S_RST || state == S_RUN;
  assign minx = state == S_RST ? RESET_INX : state == S_RUN ? run_inx : minx_q;
  // a finishing shift hands over straight to the bus wait if the strobe is still unacknowledged
  always_comb
    state_nx = state == S_RST   ? S_RUN :
               state == S_RUN   ? (load ? S_SHIFT : wait_ack ? S_MEMW : S_RUN) :
               state == S_SHIFT ? (!done ? S_SHIFT : wait_ack ? S_MEMW : S_RUN) :
               (ACK_I ? S_RUN : S_MEMW);
  // state register and held copy of the last index issued while progressing
  always_ff @(posedge clk)
    if (RST_I) begin
      state  <= S_RST;
      minx_q <= RESET_INX;
    end else begin
      state <= state_nx;
      if (progress_ucode) minx_q <= minx;
    end
endmodule
